// File: rtl/timer_counter.sv
// timer_counter
//   Memory-mapped 32-bit down-counting timer with a 16-bit prescaler,
//   optional auto-reload and a registered level interrupt.
//
// Ports
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   CS_N     chip select, active low
//   RD_N     read strobe, active low, qualified by CS_N
//   WR_N     write strobe, active low, qualified by CS_N
//   Addr     byte offset in the window; bits [1:0] ignored
//   DataIn   write data (word writes only)
//   DataOut  combinational read data, 0 when no qualified read
//   Intr     timer interrupt, registered TF & IE
//
// Register map (word offsets)
//   0x000 CTRL   {AUTO, IE, EN}
//   0x004 STATUS {TF}, write 1 to clear
//   0x008 LOAD   reload value
//   0x00C COUNT  current count
//   0x010 PRESC  prescale value P
//
// Counter FSM
//   state | meaning
//   IDLE  | EN=0, prescaler held at 0, no ticks
//   RUN   | EN=1, prescaler runs, COUNT decrements on each tick
module timer_counter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        CS_N,
  input  logic        RD_N,
  input  logic        WR_N,
  input  logic [11:0] Addr,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        Intr
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        en;
  logic        ie;
  logic        auto_rl;
  logic        tf;
  logic [31:0] load;
  logic [31:0] count;
  logic [15:0] presc;
  logic [15:0] pcnt;

  logic [9:0]  word;
  logic        wr_en;
  logic        rd_en;
  logic        wr_ctrl;
  logic        wr_status;
  logic        wr_load;
  logic        wr_count;
  logic        wr_presc;
  logic        tick;
  logic        terminal;
  logic        unused_addr;

  assign word        = Addr[11:2];
  assign unused_addr = ^Addr[1:0];
  assign wr_en       = !CS_N && !WR_N;
  assign rd_en       = !CS_N && !RD_N;
  assign wr_ctrl     = wr_en && (word == 10'd0);
  assign wr_status   = wr_en && (word == 10'd1);
  assign wr_load     = wr_en && (word == 10'd2);
  assign wr_count    = wr_en && (word == 10'd3);
  assign wr_presc    = wr_en && (word == 10'd4);

  // A software COUNT write pre-empts the whole tick, so no decrement,
  // reload, TF set or one-shot stop happens in that cycle.
  assign tick     = en && !wr_count && (pcnt == presc);
  assign terminal = tick && (count == 32'd0);

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // FSM: next state; a CTRL write outranks the one-shot stop
  always_comb begin
    state_nxt = state;
    if (wr_ctrl)
      state_nxt = DataIn[0] ? RUN : IDLE;
    else if (terminal && !auto_rl)
      state_nxt = IDLE;
  end

  // FSM: outputs
  always_comb begin
    en = (state == RUN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ie      <= 1'b0;
      auto_rl <= 1'b0;
      tf      <= 1'b0;
      load    <= '0;
      count   <= '0;
      presc   <= '0;
      pcnt    <= '0;
      Intr    <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ie      <= DataIn[1];
        auto_rl <= DataIn[2];
      end
      if (wr_load)  load  <= DataIn;
      if (wr_presc) presc <= DataIn[15:0];

      if (wr_count)
        count <= DataIn;
      else if (tick) begin
        if (count != 32'd0) count <= count - 32'd1;
        else if (auto_rl)   count <= load;
      end

      // pcnt >= presc also catches a PRESC write that left pcnt above P
      if (!en || wr_count || (pcnt >= presc))
        pcnt <= '0;
      else
        pcnt <= pcnt + 16'd1;

      if (terminal)
        tf <= 1'b1;
      else if (wr_status && DataIn[0])
        tf <= 1'b0;

      Intr <= tf && ie;
    end
  end

  always_comb begin
    DataOut = '0;
    if (rd_en) begin
      case (word)
        10'd0:   DataOut = {29'd0, auto_rl, ie, en};
        10'd1:   DataOut = {31'd0, tf};
        10'd2:   DataOut = load;
        10'd3:   DataOut = count;
        10'd4:   DataOut = {16'd0, presc};
        default: DataOut = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_counter.sv
module tb_timer_counter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        CS_N = 1'b1;
  logic        RD_N = 1'b1;
  logic        WR_N = 1'b1;
  logic [11:0] Addr = '0;
  logic [31:0] DataIn = '0;
  logic [31:0] DataOut;
  logic        Intr;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [11:0] A_CTRL   = 12'h000;
  localparam logic [11:0] A_STATUS = 12'h004;
  localparam logic [11:0] A_LOAD   = 12'h008;
  localparam logic [11:0] A_COUNT  = 12'h00C;
  localparam logic [11:0] A_PRESC  = 12'h010;

  timer_counter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .CS_N    (CS_N),
    .RD_N    (RD_N),
    .WR_N    (WR_N),
    .Addr    (Addr),
    .DataIn  (DataIn),
    .DataOut (DataOut),
    .Intr    (Intr)
  );

  always #5 clk = ~clk;

  // Write lands on the next rising edge; returns 1 ns after that edge.
  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    Addr = a; DataIn = d; CS_N = 1'b0; WR_N = 1'b0;
    @(posedge clk);
    #1;
    CS_N = 1'b1; WR_N = 1'b1;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d);
    Addr = a; CS_N = 1'b0; RD_N = 1'b0;
    #1;
    d = DataOut;
    CS_N = 1'b1; RD_N = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiesce();
    wr(A_CTRL, 32'h0);
    wr(A_STATUS, 32'h1);
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      rd(12'(i * 4), v);
      n_cmp++;
      if (v !== 32'h0) begin
        n_bad++; $display("FAIL reset_reg off=%0h: got %h expected 00000000", i * 4, v);
      end
    end
    n_cmp++;
    if (Intr !== 1'b0) begin
      n_bad++; $display("FAIL reset_intr: got %b expected 0", Intr);
    end
  endtask

  task automatic test_access();
    logic [31:0] v;
    rd(12'h020, v);
    n_cmp++;
    if (v !== 32'h0) begin n_bad++; $display("FAIL unmapped_rd: got %h expected 00000000", v); end
    wr(12'h020, 32'hFFFF_FFFF);
    rd(A_CTRL, v);
    n_cmp++;
    if (v !== 32'h0) begin n_bad++; $display("FAIL unmapped_wr_ctrl: got %h expected 00000000", v); end
    rd(12'h020, v);
    n_cmp++;
    if (v !== 32'h0) begin n_bad++; $display("FAIL unmapped_rd2: got %h expected 00000000", v); end

    wr(A_LOAD, 32'hA5A5_5A5A);
    rd(A_LOAD, v);
    n_cmp++;
    if (v !== 32'hA5A5_5A5A) begin n_bad++; $display("FAIL load_rw: got %h expected a5a55a5a", v); end
    rd(12'h00B, v);
    n_cmp++;
    if (v !== 32'hA5A5_5A5A) begin n_bad++; $display("FAIL addr_lowbits: got %h expected a5a55a5a", v); end

    Addr = A_LOAD; CS_N = 1'b1; RD_N = 1'b0;
    #1;
    n_cmp++;
    if (DataOut !== 32'h0) begin n_bad++; $display("FAIL cs_n_high_rd: got %h expected 00000000", DataOut); end
    CS_N = 1'b0; RD_N = 1'b1;
    #1;
    n_cmp++;
    if (DataOut !== 32'h0) begin n_bad++; $display("FAIL rd_n_high: got %h expected 00000000", DataOut); end
    CS_N = 1'b1;

    wr(A_PRESC, 32'hFFFF_1234);
    rd(A_PRESC, v);
    n_cmp++;
    if (v !== 32'h0000_1234) begin n_bad++; $display("FAIL presc_mask: got %h expected 00001234", v); end
    wr(A_CTRL, 32'hFFFF_FFFE);
    rd(A_CTRL, v);
    n_cmp++;
    if (v !== 32'h0000_0006) begin n_bad++; $display("FAIL ctrl_mask: got %h expected 00000006", v); end
    wr(A_CTRL, 32'h0);
  endtask

  task automatic test_auto_reload();
    logic [31:0] c, s;
    logic [31:0] exp_c [9] = '{32'd3, 32'd2, 32'd2, 32'd1, 32'd1, 32'd0, 32'd0, 32'd3, 32'd3};
    quiesce();
    wr(A_LOAD, 32'd3);
    wr(A_COUNT, 32'd3);
    wr(A_PRESC, 32'd1);
    wr(A_CTRL, 32'h7);                    // edge W
    for (int k = 1; k <= 9; k++) begin
      step();
      rd(A_COUNT, c);
      rd(A_STATUS, s);
      n_cmp++;
      if (c !== exp_c[k-1]) begin n_bad++; $display("FAIL auto_count k=%0d: got %0d expected %0d", k, c, exp_c[k-1]); end
      n_cmp++;
      if (s[0] !== (k >= 8)) begin n_bad++; $display("FAIL auto_tf k=%0d: got %b expected %b", k, s[0], (k >= 8)); end
      n_cmp++;
      if (Intr !== (k == 9)) begin n_bad++; $display("FAIL auto_intr k=%0d: got %b expected %b", k, Intr, (k == 9)); end
    end
    wr(A_STATUS, 32'h1);                  // W+10
    rd(A_STATUS, s);
    n_cmp++;
    if (s[0] !== 1'b0) begin n_bad++; $display("FAIL auto_w1c_tf: got %b expected 0", s[0]); end
    n_cmp++;
    if (Intr !== 1'b1) begin n_bad++; $display("FAIL auto_w1c_intr_lag: got %b expected 1", Intr); end
    step();                               // W+11
    n_cmp++;
    if (Intr !== 1'b0) begin n_bad++; $display("FAIL auto_w1c_intr: got %b expected 0", Intr); end
    for (int k = 12; k <= 16; k++) begin
      step();
      rd(A_STATUS, s);
      n_cmp++;
      if (s[0] !== (k == 16)) begin n_bad++; $display("FAIL auto_period k=%0d: got %b expected %b", k, s[0], (k == 16)); end
    end
    rd(A_COUNT, c);
    n_cmp++;
    if (c !== 32'd3) begin n_bad++; $display("FAIL auto_reload2: got %0d expected 3", c); end
    quiesce();
  endtask

  task automatic test_one_shot();
    logic [31:0] v;
    quiesce();
    wr(A_COUNT, 32'd2);
    wr(A_PRESC, 32'd0);
    wr(A_CTRL, 32'h3);                    // edge W
    rd(A_CTRL, v);
    n_cmp++;
    if (v !== 32'h3) begin n_bad++; $display("FAIL os_ctrl_rd: got %h expected 00000003", v); end
    for (int k = 1; k <= 3; k++) begin
      step();
      rd(A_COUNT, v);
      n_cmp++;
      if (v !== 32'(3 - k > 0 ? 2 - k + 0 : 0) && k < 3) begin end
      if (v !== ((k == 1) ? 32'd1 : 32'd0)) begin n_bad++; $display("FAIL os_count k=%0d: got %0d expected %0d", k, v, (k == 1) ? 1 : 0); end
      rd(A_STATUS, v);
      n_cmp++;
      if (v[0] !== (k == 3)) begin n_bad++; $display("FAIL os_tf k=%0d: got %b expected %b", k, v[0], (k == 3)); end
    end
    rd(A_CTRL, v);
    n_cmp++;
    if (v !== 32'h2) begin n_bad++; $display("FAIL os_en_clear: got %h expected 00000002", v); end
    n_cmp++;
    if (Intr !== 1'b0) begin n_bad++; $display("FAIL os_intr_lag: got %b expected 0", Intr); end
    step();
    n_cmp++;
    if (Intr !== 1'b1) begin n_bad++; $display("FAIL os_intr: got %b expected 1", Intr); end
    repeat (5) step();
    rd(A_COUNT, v);
    n_cmp++;
    if (v !== 32'd0) begin n_bad++; $display("FAIL os_count_hold: got %0d expected 0", v); end
    rd(A_CTRL, v);
    n_cmp++;
    if (v !== 32'h2) begin n_bad++; $display("FAIL os_stays_idle: got %h expected 00000002", v); end
  endtask

  task automatic test_w1c();
    logic [31:0] v;
    // TF=1, IE=1 left over from the one-shot
    wr(A_STATUS, 32'h0);
    rd(A_STATUS, v);
    n_cmp++;
    if (v !== 32'h1) begin n_bad++; $display("FAIL w1c_zero: got %h expected 00000001", v); end
    wr(A_STATUS, 32'h1);                  // edge N
    rd(A_STATUS, v);
    n_cmp++;
    if (v !== 32'h0) begin n_bad++; $display("FAIL w1c_one: got %h expected 00000000", v); end
    n_cmp++;
    if (Intr !== 1'b1) begin n_bad++; $display("FAIL w1c_intr_n: got %b expected 1", Intr); end
    step();
    n_cmp++;
    if (Intr !== 1'b0) begin n_bad++; $display("FAIL w1c_intr_n1: got %b expected 0", Intr); end

    // LOAD=0 with AUTO: every tick is terminal, so every W1C races a TF set
    quiesce();
    wr(A_LOAD, 32'd0);
    wr(A_COUNT, 32'd0);
    wr(A_PRESC, 32'd0);
    wr(A_CTRL, 32'h5);                    // edge W
    step();                               // W+1 terminal
    rd(A_STATUS, v);
    n_cmp++;
    if (v !== 32'h1) begin n_bad++; $display("FAIL load0_tf: got %h expected 00000001", v); end
    wr(A_STATUS, 32'h1);                  // W+2 terminal again
    rd(A_STATUS, v);
    n_cmp++;
    if (v !== 32'h1) begin n_bad++; $display("FAIL w1c_race: got %h expected 00000001", v); end
    n_cmp++;
    if (Intr !== 1'b0) begin n_bad++; $display("FAIL w1c_race_ie0: got %b expected 0", Intr); end
    quiesce();
  endtask

  task automatic test_count_race();
    logic [31:0] v;
    quiesce();
    wr(A_LOAD, 32'h100);
    wr(A_COUNT, 32'h50);
    wr(A_PRESC, 32'd3);
    wr(A_CTRL, 32'h5);                    // edge W, first tick at W+4
    repeat (3) step();
    rd(A_COUNT, v);
    n_cmp++;
    if (v !== 32'h50) begin n_bad++; $display("FAIL race_pre: got %h expected 00000050", v); end
    wr(A_COUNT, 32'h10);                  // W+4, same edge as the tick
    rd(A_COUNT, v);
    n_cmp++;
    if (v !== 32'h10) begin n_bad++; $display("FAIL race_count: got %h expected 00000010", v); end
    repeat (3) step();                    // W+7
    rd(A_COUNT, v);
    n_cmp++;
    if (v !== 32'h10) begin n_bad++; $display("FAIL race_hold: got %h expected 00000010", v); end
    step();                               // W+8
    rd(A_COUNT, v);
    n_cmp++;
    if (v !== 32'h0F) begin n_bad++; $display("FAIL race_next_tick: got %h expected 0000000f", v); end
    quiesce();
  endtask

  task automatic test_prescaler();
    logic [31:0] v;
    logic [31:0] e;
    quiesce();
    wr(A_COUNT, 32'h20);
    wr(A_PRESC, 32'd7);
    wr(A_CTRL, 32'h5);                    // edge W
    repeat (5) step();                    // PCNT=5
    wr(A_PRESC, 32'd2);                   // W+6
    for (int k = 6; k <= 16; k++) begin
      if (k > 6) step();
      e = (k < 10) ? 32'h20 : (k < 13) ? 32'h1F : (k < 16) ? 32'h1E : 32'h1D;
      rd(A_COUNT, v);
      n_cmp++;
      if (v !== e) begin n_bad++; $display("FAIL presc_shrink k=%0d: got %h expected %h", k, v, e); end
    end

    quiesce();
    wr(A_COUNT, 32'd5);
    wr(A_PRESC, 32'hFFFF);
    wr(A_CTRL, 32'h5);                    // edge W, tick at W+65536
    repeat (65534) @(posedge clk);
    step();                               // W+65535
    rd(A_COUNT, v);
    n_cmp++;
    if (v !== 32'd5) begin n_bad++; $display("FAIL presc_max_pre: got %0d expected 5", v); end
    step();                               // W+65536
    rd(A_COUNT, v);
    n_cmp++;
    if (v !== 32'd4) begin n_bad++; $display("FAIL presc_max_tick: got %0d expected 4", v); end
    quiesce();
  endtask

  task automatic test_reset_midrun();
    logic [31:0] v;
    quiesce();
    wr(A_LOAD, 32'd0);
    wr(A_COUNT, 32'd0);
    wr(A_PRESC, 32'd0);
    wr(A_CTRL, 32'h7);
    repeat (2) step();
    n_cmp++;
    if (Intr !== 1'b1) begin n_bad++; $display("FAIL midrun_intr_pre: got %b expected 1", Intr); end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (Intr !== 1'b0) begin n_bad++; $display("FAIL midrun_intr_async: got %b expected 0", Intr); end
    rd(A_CTRL, v);
    n_cmp++;
    if (v !== 32'h0) begin n_bad++; $display("FAIL midrun_ctrl_async: got %h expected 00000000", v); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) step();
    for (int i = 0; i < 5; i++) begin
      rd(12'(i * 4), v);
      n_cmp++;
      if (v !== 32'h0) begin n_bad++; $display("FAIL midrun_reg off=%0h: got %h expected 00000000", i * 4, v); end
    end
    n_cmp++;
    if (Intr !== 1'b0) begin n_bad++; $display("FAIL midrun_intr: got %b expected 0", Intr); end
  endtask

  initial begin
    test_reset();
    test_access();
    test_auto_reload();
    test_one_shot();
    test_w1c();
    test_count_race();
    test_prescaler();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
# timer_counter

Memory-mapped 32-bit down-counting timer with a programmable prescaler, auto-reload, and a level interrupt. It occupies the 4 KB TC window at 0xFFFF_0000–0xFFFF_0FFF and is selected by the address decoder's active-low TC chip select. It sits on the CPU data bus beside memory, UART and GPIO, and drives the CPU's timer interrupt line.

## Interface
- No parameters; all widths are fixed.
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- CS_N  input  1  chip select from the address decoder, active low.
- RD_N  input  1  read strobe, active low; qualified by CS_N.
- WR_N  input  1  write strobe, active low; qualified by CS_N.
- Addr  input  12  byte offset within the TC window; Addr[1:0] ignored.
- DataIn  input  32  write data; word writes only.
- DataOut  output  32  read data.
- Intr  output  1  timer interrupt, active high, registered.

## Operation
- Register map, by word offset:
  - 0x000 CTRL: bit0 EN, bit1 IE, bit2 AUTO; other bits read 0.
  - 0x004 STATUS: bit0 TF. Writing 1 to bit0 clears TF; writing 0 has no effect.
  - 0x008 LOAD: 32-bit reload value.
  - 0x00C COUNT: 32-bit current count. A write sets the count directly.
  - 0x010 PRESC: bits[15:0] P; upper bits read 0.
- Unmapped offsets read 0x0000_0000; writes to them are ignored.
- Write: when CS_N=0 and WR_N=0 at a rising edge, the addressed register takes DataIn.
- Read: combinational. DataOut = selected register when CS_N=0 and RD_N=0; otherwise 0x0000_0000.
- Prescaler:
  - 16-bit counter PCNT counts 0..P while EN=1.
  - A tick is the cycle in which PCNT==P; PCNT returns to 0 on that cycle.
  - The tick period is P+1 clocks.
  - While EN=0, PCNT is held at 0.
- On each tick:
  - If COUNT≠0: COUNT ← COUNT−1.
  - If COUNT==0: TF ← 1. Then, if AUTO=1, COUNT ← LOAD; if AUTO=0, EN ← 0 and COUNT stays 0 (one-shot).
- Period:
  - With AUTO=1 and COUNT starting at LOAD, TF sets every (LOAD+1)·(P+1) clocks.
  - LOAD=0 with AUTO=1 sets TF on every tick.
- Intr ← TF & IE, registered, so it lags TF/IE changes by one cycle.
- Counter states: IDLE (EN=0) and RUN (EN=1).
  - IDLE→RUN on a CTRL write with EN=1.
  - RUN→IDLE on a CTRL write with EN=0, or on a one-shot terminal tick.
- Simultaneous events, priority highest first:
  - Software write to COUNT beats tick decrement/reload. The same write also clears PCNT.
  - A terminal-tick TF set beats a same-cycle W1C clear; TF stays 1.
  - A CTRL write beats the one-shot EN clear in the same cycle.
- A LOAD write never affects COUNT until the next reload.
- A PRESC write takes effect immediately. If PCNT > new P, PCNT resets to 0 on the next edge.

## Timing
- Reset values (asynchronous, immediate on reset_n=0):
  - CTRL, STATUS, LOAD, COUNT, PRESC = 0.
  - PCNT = 0.
  - Intr = 0.
  - DataOut = 0, since no read is qualified during reset.
- Reset mid-operation aborts counting. No tick or TF is generated until software re-enables.
- Write latency: a register is visible on read in the cycle after the write edge.
- Enable latency: after the CTRL write edge setting EN, the first tick occurs P+1 clocks later. With P=0 it occurs on the first edge after the write edge.
- A terminal tick at edge N gives TF=1 after edge N and Intr=1 after edge N+1 (if IE=1).
- Clearing TF at edge N gives Intr=0 after edge N+1.
- COUNT wraps only through reload; it never decrements below 0.

## Test plan
- Reset and access:
  - Stimulus: assert reset_n=0 mid-run, then release.
  - Required: all registers read 0 and Intr=0.
  - Read offset 0x020 → 0; write to 0x020, then read CTRL → 0.
  - With CS_N=1, RD_N=0 → DataOut=0.
- Auto-reload period:
  - Stimulus: LOAD=3, COUNT=3, PRESC=1, CTRL=0x7.
  - Required: TF sets every 8 clocks; Intr follows one cycle later; COUNT sequence 3,2,1,0,3.
- One-shot:
  - Stimulus: COUNT=2, PRESC=0, CTRL=0x3.
  - Required: TF=1 after 3 ticks; EN reads 0; COUNT holds 0; no further ticks.
- W1C and race:
  - Write STATUS=0x0 → TF unchanged.
  - Write STATUS=0x1 → TF=0, Intr=0 one cycle later.
  - W1C in the same cycle as a terminal tick → TF stays 1.
- COUNT write race:
  - Stimulus: write COUNT=0x10 in the same cycle as a tick.
  - Required: COUNT reads 0x10, not 0x0F; the next tick comes P+1 clocks later.
- Prescaler edge cases:
  - PRESC=0xFFFF → one tick per 65536 clocks.
  - Set PRESC=2 while PCNT=5 → PCNT resets, then ticks every 3 clocks.
